// File: rtl/bmp_pkg.sv
// Shared types and helpers for the bitmap slicer: default geometry,
// slice-stream direction and index-width helper.
package bmp_pkg;

   localparam int DEF_COLS = 24;
   localparam int DEF_ROWS = 64;

   typedef enum logic {
      DIR_UP,
      DIR_DOWN
   } dir_e;

   // A depth of one still needs a one-bit counter.
   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/bmp_stream.sv
// One slice stream: index counter, request acceptance and the
// valid/last/done flags for a single walk direction.
module bmp_stream
   import bmp_pkg::*;
#(
   parameter int   DEPTH = 4,
   parameter dir_e DIR   = DIR_DOWN
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        rewind_i,
   input  logic                        en_i,
   input  logic                        req_i,
   output logic [idx_w(DEPTH)-1:0]     idx_o,
   output logic                        accept_o,
   output logic                        valid_o,
   output logic                        last_o,
   output logic                        done_o
);

   localparam int IW = idx_w(DEPTH);
   localparam logic [IW-1:0] FIRST = (DIR == DIR_DOWN) ? IW'(DEPTH-1) : '0;
   localparam logic [IW-1:0] TERM  = (DIR == DIR_DOWN) ? '0 : IW'(DEPTH-1);

   logic [IW-1:0] idx_q, idx_d;
   logic          done_q, done_d;
   logic          valid_q, valid_d;
   logic          last_q, last_d;
   logic          accept;

   assign accept = req_i && en_i && !done_q;

   always_comb begin
      idx_d   = idx_q;
      done_d  = done_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
      if (rewind_i) begin
         idx_d  = FIRST;
         done_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         last_d  = (idx_q == TERM);
         // The terminal index holds; done blocks any further stepping.
         if (idx_q == TERM) done_d = 1'b1;
         else if (DIR == DIR_DOWN) idx_d = idx_q - 1'b1;
         else idx_d = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         idx_q   <= FIRST;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign idx_o    = idx_q;
   assign accept_o = accept;
   assign valid_o  = valid_q;
   assign last_o   = last_q;
   assign done_o   = done_q;

endmodule

// File: rtl/bmp_slicer.sv
// Bitmap store-and-slice engine: active/shadow bank control plus column,
// top-down and bottom-up slice streams over the active bitmap.
module bmp_slicer
   import bmp_pkg::*;
#(
   parameter int COLS       = DEF_COLS,
   parameter int ROWS       = DEF_ROWS,
   parameter bit DOUBLE_BUF = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 load_valid_i,
   output logic                 load_ready_o,
   input  logic [COLS*ROWS-1:0] bmp_i,
   output logic                 start_o,
   input  logic                 release_i,
   input  logic                 col_req_i,
   input  logic                 top_req_i,
   input  logic                 bot_req_i,
   output logic                 col_valid_o,
   output logic                 top_valid_o,
   output logic                 bot_valid_o,
   output logic [ROWS-1:0]      col_data_o,
   output logic [COLS-1:0]      top_data_o,
   output logic [COLS-1:0]      bot_data_o,
   output logic                 col_last_o,
   output logic                 top_last_o,
   output logic                 bot_last_o,
   output logic                 col_done_o,
   output logic                 top_done_o,
   output logic                 bot_done_o,
   output logic                 busy_o
);

   localparam int CW = idx_w(COLS);
   localparam int RW = idx_w(ROWS);

   logic [COLS*ROWS-1:0] active_q, active_d;
   logic [COLS*ROWS-1:0] shadow_q, shadow_d;
   logic                 shadow_full_q, shadow_full_d;
   logic                 busy_q, busy_d;
   logic                 start_q;
   logic [ROWS-1:0]      col_data_q, col_slice;
   logic [COLS-1:0]      top_data_q, top_slice;
   logic [COLS-1:0]      bot_data_q, bot_slice;

   logic          swap, consume, free, en, load_ready;
   logic [CW-1:0] col_idx;
   logic [RW-1:0] top_idx, bot_idx;
   logic          col_acc, top_acc, bot_acc;
   logic          col_done, top_done, bot_done;

   assign consume = busy_q && ((col_done && top_done && bot_done) || release_i);
   assign free    = !busy_q || consume;
   assign en      = busy_q && !swap;

   always_comb begin
      active_d      = active_q;
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
      swap          = 1'b0;
      load_ready    = 1'b0;
      if (DOUBLE_BUF) begin
         load_ready = !shadow_full_q;
         if (shadow_full_q && free) begin
            swap          = 1'b1;
            active_d      = shadow_q;
            shadow_full_d = 1'b0;
         end else if (load_valid_i && !shadow_full_q) begin
            // A free active bank is loaded directly, skipping the shadow hop.
            if (free) begin
               swap     = 1'b1;
               active_d = bmp_i;
            end else begin
               shadow_d      = bmp_i;
               shadow_full_d = 1'b1;
            end
         end
      end else begin
         load_ready = free;
         if (load_valid_i && free) begin
            swap     = 1'b1;
            active_d = bmp_i;
         end
      end
      if (swap) busy_d = 1'b1;
      else if (consume) busy_d = 1'b0;
      else busy_d = busy_q;
   end

   always_comb begin
      col_slice = '0;
      for (int r = 0; r < ROWS; r++)
         col_slice[ROWS-1-r] = active_q[r*COLS + int'(col_idx)];
      top_slice = active_q[int'(top_idx)*COLS +: COLS];
      bot_slice = active_q[int'(bot_idx)*COLS +: COLS];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         active_q      <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         busy_q        <= 1'b0;
         start_q       <= 1'b0;
         col_data_q    <= '0;
         top_data_q    <= '0;
         bot_data_q    <= '0;
      end else begin
         active_q      <= active_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         busy_q        <= busy_d;
         start_q       <= swap;
         if (col_acc) col_data_q <= col_slice;
         if (top_acc) top_data_q <= top_slice;
         if (bot_acc) bot_data_q <= bot_slice;
      end
   end

   bmp_stream #(.DEPTH(COLS), .DIR(DIR_DOWN)) u_col (
      .clk_i(clk_i), .reset_i(reset_i), .rewind_i(swap), .en_i(en),
      .req_i(col_req_i), .idx_o(col_idx), .accept_o(col_acc),
      .valid_o(col_valid_o), .last_o(col_last_o), .done_o(col_done)
   );

   bmp_stream #(.DEPTH(ROWS), .DIR(DIR_DOWN)) u_top (
      .clk_i(clk_i), .reset_i(reset_i), .rewind_i(swap), .en_i(en),
      .req_i(top_req_i), .idx_o(top_idx), .accept_o(top_acc),
      .valid_o(top_valid_o), .last_o(top_last_o), .done_o(top_done)
   );

   bmp_stream #(.DEPTH(ROWS), .DIR(DIR_UP)) u_bot (
      .clk_i(clk_i), .reset_i(reset_i), .rewind_i(swap), .en_i(en),
      .req_i(bot_req_i), .idx_o(bot_idx), .accept_o(bot_acc),
      .valid_o(bot_valid_o), .last_o(bot_last_o), .done_o(bot_done)
   );

   assign load_ready_o = load_ready;
   assign start_o      = start_q;
   assign busy_o       = busy_q;
   assign col_data_o   = col_data_q;
   assign top_data_o   = top_data_q;
   assign bot_data_o   = bot_data_q;
   assign col_done_o   = col_done;
   assign top_done_o   = top_done;
   assign bot_done_o   = bot_done;

endmodule

// File: tb/tb_bmp_slicer.sv
// Directed bench for bmp_slicer at COLS=4, ROWS=3: one double-buffered and
// one single-bank instance, slice expectations derived from the bitmaps.
module tb_bmp_slicer;

   localparam int C = 4;
   localparam int R = 3;

   typedef struct {
      logic [3:0] d;
      logic       l;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // double-buffered instance
   logic           l1_lv, l1_lr, l1_start, l1_rel, l1_creq, l1_treq, l1_breq;
   logic [C*R-1:0] l1_bmp;
   logic           l1_cv, l1_tv, l1_bv, l1_cl, l1_tl, l1_bl, l1_cd, l1_td, l1_bd, l1_busy;
   logic [R-1:0]   l1_cdat;
   logic [C-1:0]   l1_tdat, l1_bdat;

   // single-bank instance
   logic           l0_lv, l0_lr, l0_start, l0_rel, l0_creq, l0_treq, l0_breq;
   logic [C*R-1:0] l0_bmp;
   logic           l0_cv, l0_tv, l0_bv, l0_cl, l0_tl, l0_bl, l0_cd, l0_td, l0_bd, l0_busy;
   logic [R-1:0]   l0_cdat;
   logic [C-1:0]   l0_tdat, l0_bdat;

   bmp_slicer #(.COLS(C), .ROWS(R), .DOUBLE_BUF(1'b1)) u1 (
      .clk_i(clk), .reset_i(rst), .load_valid_i(l1_lv), .load_ready_o(l1_lr),
      .bmp_i(l1_bmp), .start_o(l1_start), .release_i(l1_rel),
      .col_req_i(l1_creq), .top_req_i(l1_treq), .bot_req_i(l1_breq),
      .col_valid_o(l1_cv), .top_valid_o(l1_tv), .bot_valid_o(l1_bv),
      .col_data_o(l1_cdat), .top_data_o(l1_tdat), .bot_data_o(l1_bdat),
      .col_last_o(l1_cl), .top_last_o(l1_tl), .bot_last_o(l1_bl),
      .col_done_o(l1_cd), .top_done_o(l1_td), .bot_done_o(l1_bd), .busy_o(l1_busy)
   );

   bmp_slicer #(.COLS(C), .ROWS(R), .DOUBLE_BUF(1'b0)) u0 (
      .clk_i(clk), .reset_i(rst), .load_valid_i(l0_lv), .load_ready_o(l0_lr),
      .bmp_i(l0_bmp), .start_o(l0_start), .release_i(l0_rel),
      .col_req_i(l0_creq), .top_req_i(l0_treq), .bot_req_i(l0_breq),
      .col_valid_o(l0_cv), .top_valid_o(l0_tv), .bot_valid_o(l0_bv),
      .col_data_o(l0_cdat), .top_data_o(l0_tdat), .bot_data_o(l0_bdat),
      .col_last_o(l0_cl), .top_last_o(l0_tl), .bot_last_o(l0_bl),
      .col_done_o(l0_cd), .top_done_o(l0_td), .bot_done_o(l0_bd), .busy_o(l0_busy)
   );

   int checks = 0;
   int errors = 0;
   exp_t cq[$], tq[$], bq[$];

   // rows listed row0..row2 from the low bits up
   localparam logic [C*R-1:0] BA = 12'hF5A;
   localparam logic [C*R-1:0] BB = 12'h3C9;
   localparam logic [C*R-1:0] BC = 12'h777;

   function automatic logic [3:0] mcol(input logic [C*R-1:0] b, input int c);
      logic [3:0] v;
      v = '0;
      for (int r = 0; r < R; r++) v[R-1-r] = b[r*C + c];
      return v;
   endfunction

   function automatic logic [3:0] mrow(input logic [C*R-1:0] b, input int r);
      return b[r*C +: C];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string s, input logic [3:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      if (s == "col") cq.push_back(e);
      else if (s == "top") tq.push_back(e);
      else bq.push_back(e);
   endtask

   // every accepted request must produce exactly one slice one cycle later
   task automatic scb();
      exp_t e;
      if (cq.size() > 0) begin
         e = cq.pop_front();
         chk("col_valid", l1_cv, 1);
         chk("col_data", l1_cdat, e.d);
         chk("col_last", l1_cl, e.l);
      end else chk("col_novalid", l1_cv, 0);
      if (tq.size() > 0) begin
         e = tq.pop_front();
         chk("top_valid", l1_tv, 1);
         chk("top_data", l1_tdat, e.d);
         chk("top_last", l1_tl, e.l);
      end else chk("top_novalid", l1_tv, 0);
      if (bq.size() > 0) begin
         e = bq.pop_front();
         chk("bot_valid", l1_bv, 1);
         chk("bot_data", l1_bdat, e.d);
         chk("bot_last", l1_bl, e.l);
      end else chk("bot_novalid", l1_bv, 0);
   endtask

   initial begin
      rst = 1'b1;
      {l1_lv, l1_rel, l1_creq, l1_treq, l1_breq} = '0;
      {l0_lv, l0_rel, l0_creq, l0_treq, l0_breq} = '0;
      l1_bmp = '0;
      l0_bmp = '0;
      #2;
      chk("rst_load_ready", l1_lr, 1);
      chk("rst_start", l1_start, 0);
      chk("rst_busy", l1_busy, 0);
      chk("rst_valids", {l1_cv, l1_tv, l1_bv, l1_cl, l1_tl, l1_bl}, 0);
      chk("rst_dones", {l1_cd, l1_td, l1_bd}, 0);
      chk("rst_data", {l1_cdat, l1_tdat, l1_bdat}, 0);
      chk("rst0_load_ready", l0_lr, 1);
      chk("rst0_busy", l0_busy, 0);
      #10 rst = 1'b0;
      tick();

      // load into a free bank: start one cycle later
      l1_lv = 1'b1; l1_bmp = BA;
      tick();
      l1_lv = 1'b0;
      chk("load_start", l1_start, 1);
      chk("load_busy", l1_busy, 1);
      chk("load_ready_after", l1_lr, 1);

      // column stream c=3..0, then one extra request
      l1_creq = 1'b1;
      for (int c = C-1; c >= 0; c--) begin
         push("col", mcol(BA, c), c == 0);
         tick();
         scb();
      end
      chk("col_spec_last", l1_cdat, 3'b011);
      tick();
      scb();
      l1_creq = 1'b0;
      chk("col_done", l1_cd, 1);

      // top and bottom streams together, then one extra request
      l1_treq = 1'b1; l1_breq = 1'b1;
      for (int i = 0; i < R; i++) begin
         push("top", mrow(BA, R-1-i), i == R-1);
         push("bot", mrow(BA, i), i == R-1);
         tick();
         scb();
      end
      tick();
      scb();
      l1_treq = 1'b0; l1_breq = 1'b0;
      chk("top_done", l1_td, 1);
      chk("bot_done", l1_bd, 1);
      chk("consumed_busy", l1_busy, 0);
      chk("data_held", l1_tdat, 4'hA);

      // reload A, two slices, queue B in the shadow while A streams
      l1_lv = 1'b1; l1_bmp = BA;
      tick();
      chk("reload_start", l1_start, 1);
      l1_lv = 1'b0;
      l1_creq = 1'b1;
      push("col", mcol(BA, 3), 1'b0); tick(); scb();
      push("col", mcol(BA, 2), 1'b0);
      l1_lv = 1'b1; l1_bmp = BB;
      tick(); scb();
      l1_lv = 1'b0;
      chk("shadow_load_ready", l1_lr, 0);
      chk("shadow_no_start", l1_start, 0);
      push("col", mcol(BA, 1), 1'b0); tick(); scb();

      // release swaps in B; the request in the swap cycle is dropped
      l1_rel = 1'b1;
      tick(); scb();
      l1_rel = 1'b0;
      chk("swap_start", l1_start, 1);
      chk("swap_load_ready", l1_lr, 1);
      chk("swap_busy", l1_busy, 1);
      chk("swap_col_done", l1_cd, 0);
      push("col", mcol(BB, 3), 1'b0); tick(); scb();
      push("col", mcol(BB, 2), 1'b0); tick(); scb();
      l1_creq = 1'b0;

      // fill shadow, then reset mid-cycle
      l1_lv = 1'b1; l1_bmp = BC;
      tick();
      l1_lv = 1'b0;
      chk("shadow2_load_ready", l1_lr, 0);
      #2 rst = 1'b1;
      #1;
      chk("mrst_valid", {l1_cv, l1_cl}, 0);
      chk("mrst_data", {l1_cdat, l1_tdat, l1_bdat}, 0);
      chk("mrst_busy", l1_busy, 0);
      chk("mrst_load_ready", l1_lr, 1);
      chk("mrst_start", l1_start, 0);
      #3 rst = 1'b0;
      tick();
      chk("mrst_shadow_empty_start", l1_start, 0);
      chk("mrst_shadow_empty_busy", l1_busy, 0);

      // single bank: load blocked while busy, accepted on the consume cycle
      l0_lv = 1'b1; l0_bmp = BA;
      tick();
      chk("sb_start", l0_start, 1);
      l0_bmp = BB;
      tick();
      chk("sb_blocked_ready", l0_lr, 0);
      chk("sb_blocked_start", l0_start, 0);
      l0_creq = 1'b1; l0_treq = 1'b1; l0_breq = 1'b1;
      for (int i = 0; i < C; i++) begin
         if (i == R) begin l0_treq = 1'b0; l0_breq = 1'b0; end
         tick();
         chk("sb_col_data", l0_cdat, mcol(BA, C-1-i));
         chk("sb_col_valid", l0_cv, 1);
         if (i < R) begin
            chk("sb_top_data", l0_tdat, mrow(BA, R-1-i));
            chk("sb_bot_data", l0_bdat, mrow(BA, i));
         end
         if (i < C-1) chk("sb_wait_ready", l0_lr, 0);
      end
      l0_creq = 1'b0;
      chk("sb_consume_ready", l0_lr, 1);
      tick();
      l0_lv = 1'b0;
      chk("sb_swap_start", l0_start, 1);
      chk("sb_swap_busy", l0_busy, 1);
      chk("sb_swap_done", l0_cd, 0);
      l0_creq = 1'b1;
      tick();
      l0_creq = 1'b0;
      chk("sb_b_col", l0_cdat, mcol(BB, C-1));
      chk("sb_b_valid", l0_cv, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bmp_slicer.md
# bmp_slicer

Parametrised bitmap store-and-slice engine sitting between the bitmap loader and the compare/accumulate ALU. It holds a COLS×ROWS bitmap and serves three independent slice streams on request: columns, rows from the top down, and rows from the bottom up. It adds an optional shadow buffer so the next bitmap loads while the current one is being sliced, explicit per-stream last/done flags, and an early-release input.

## Interface
- COLS, 24, bits per row (number of columns)
- ROWS, 64, number of rows
- DOUBLE_BUF, 1, 1 = shadow bank present; 0 = single bank
- clk  in  1  sole clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- load_valid  in  1  bmp_in holds a bitmap to store
- load_ready  out  1  bitmap accepted when load_valid && load_ready
- bmp_in  in  COLS*ROWS  bitmap; row r = bmp_in[(r+1)*COLS-1 : r*COLS]
- start  out  1  one-cycle pulse: new bitmap active, counters rewound
- release  in  1  ALU finished with active bitmap early
- col_req / top_req / bot_req  in  1  request next slice of the stream
- col_valid / top_valid / bot_valid  out  1  one-cycle pulse, slice presented
- col_data  out  ROWS  column slice; col_data[ROWS-1-r] = row r bit c
- top_data / bot_data  out  COLS  row slice
- col_last / top_last / bot_last  out  1  pulses with valid for final slice
- col_done / top_done / bot_done  out  1  level; stream exhausted
- busy  out  1  active bank holds an unconsumed bitmap

## Operation
- Column stream: index c from COLS-1 down to 0. Top stream: row from ROWS-1 down to 0. Bottom stream: row from 0 up to ROWS-1.
- Accepted req (active bank valid, stream not done, no swap this cycle): next cycle, data = slice at current index, valid=1, last=1 if index is terminal; index steps. After terminal slice, done=1.
- data registers hold the last slice until the next accepted req; req while done or not busy is ignored (no valid).
- Streams fully independent; simultaneous reqs on all three are all served in the same cycle.
- Consumed = all three done, or release. On consume, busy clears next cycle unless a swap occurs.
- DOUBLE_BUF=1: load_ready = !shadow_full. Load writes shadow. Swap when shadow_full && (!busy || consume): active <= shadow, shadow_full clears, counters rewind, busy=1, start pulses next cycle.
- DOUBLE_BUF=0: load_ready = !busy || consume; load writes active directly, same rewind/start behaviour.
- Req in the swap/load cycle is dropped (not queued); the bench must re-request after start.
- release while !busy: ignored.

## Timing
- Reset values: load_ready=1, start=0, all valid/last/done=0, all data=0, busy=0, counters rewound, shadow empty.
- Req→valid latency: 1 cycle. Load→start latency: 1 cycle if the active bank is free, otherwise 1 cycle after consume.
- Full throughput: req every cycle yields valid every cycle; COLS column slices in COLS cycles.
- Load and consume in the same cycle (DOUBLE_BUF=0): load wins, start pulses next cycle.
- Reset mid-stream: all state cleared immediately; shadow content discarded.
- Counter widths $clog2 of depth; no wrap: terminal index never steps further.

## Structure
- Package bmp_pkg: default COLS/ROWS, index-width helpers, stream direction enum (DIR_UP, DIR_DOWN).
- Sub-module bmp_stream (DEPTH, DIR): index counter, req acceptance, valid/last/done generation; instantiated three times. Slice muxing and bank/swap control stay in bmp_slicer.

## Test plan
- COLS=4, ROWS=3, bitmap rows {4'hA, 4'h5, 4'hF} (row0..2): four col_reqs -> col_data 3'b101, 3'b011, 3'b101, 3'b011 (c=3..0), col_last on the 4th, col_done=1.
- Same bitmap, top_req and bot_req every cycle together -> top 4'hF, 4'h5, 4'hA; bot 4'hA, 4'h5, 4'hF; both last on cycle 3; extra reqs produce no valid.
- DOUBLE_BUF=1: load A, then load B while A streams -> load_ready=0 after B; release -> next cycle start=1, col_data from B on next req, load_ready=1.
- DOUBLE_BUF=0: load while busy -> load_ready=0 until all three done; then load accepted, start pulses 1 cycle later.
- Req asserted in swap cycle -> no valid next cycle; index still at COLS-1 after start.
- Assert reset mid-stream (after 2 col slices) -> all outputs 0 same cycle, busy=0, load_ready=1, shadow empty.
